// File: rtl/activation_buffer_writer.sv
// Packs a stream of activation elements four per word and writes each word to the buffer at incrementing addresses.
// Latency: 1 cycle from accepting the completing element to wr_en. data_ready_o is high for the whole FILL state, so the stream never stalls.
module activation_buffer_writer #(
   parameter int DATA_WIDTH        = 7,
   parameter int BUFFER_ADDR_WIDTH = 15,
   parameter int COUNT_WIDTH       = 17
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start_i,
   input  logic [BUFFER_ADDR_WIDTH-1:0] base_addr_i,
   input  logic [COUNT_WIDTH-1:0]       num_elems_i,
   input  logic                         data_valid_i,
   input  logic [DATA_WIDTH-1:0]        data_i,
   output logic                         data_ready_o,
   output logic                         buffer_wr_en_o,
   output logic [BUFFER_ADDR_WIDTH-1:0] buffer_wr_addr_o,
   output logic [DATA_WIDTH*4-1:0]      buffer_data_o,
   output logic                         busy_o,
   output logic                         done_o
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t                         state_q, state_d;
   logic [1:0]                     lane_q, lane_d;
   logic [COUNT_WIDTH-1:0]         remain_q, remain_d;
   logic [BUFFER_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH*4-1:0]        pack_q, pack_d;
   logic                           wr_en_q, wr_en_d;
   logic [BUFFER_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH*4-1:0]        wr_data_q, wr_data_d;
   logic [DATA_WIDTH*4-1:0]        word;
   logic                           last_elem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lane_q    <= '0;
         remain_q  <= '0;
         addr_q    <= '0;
         pack_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         remain_q  <= remain_d;
         addr_q    <= addr_d;
         pack_q    <= pack_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      remain_d  = remain_q;
      addr_d    = addr_q;
      pack_d    = pack_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      last_elem = (remain_q == COUNT_WIDTH'(1));
      // Current partial word with the incoming element merged into its lane.
      word      = pack_q;
      word[lane_q*DATA_WIDTH +: DATA_WIDTH] = data_i;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (num_elems_i != '0) begin
                  remain_d = num_elems_i;
                  addr_d   = base_addr_i;
                  lane_d   = '0;
                  pack_d   = '0;
                  state_d  = S_FILL;
               end else begin
                  state_d  = S_DONE;
               end
            end
         end
         S_FILL: begin
            if (data_valid_i) begin
               remain_d = remain_q - COUNT_WIDTH'(1);
               lane_d   = lane_q + 2'd1;
               if (lane_q == 2'd3 || last_elem) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = word;
                  addr_d    = addr_q + BUFFER_ADDR_WIDTH'(1);
                  pack_d    = '0;
               end else begin
                  pack_d    = word;
               end
               if (last_elem) begin
                  lane_d  = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign data_ready_o     = (state_q == S_FILL);
   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = (state_q == S_DONE);
   assign buffer_wr_en_o   = wr_en_q;
   assign buffer_wr_addr_o = wr_addr_q;
   assign buffer_data_o    = wr_data_q;

endmodule

// File: tb/tb_activation_buffer_writer.sv
// Bench for activation_buffer_writer: directed job table, reset-abort sequence and random jobs against a word-level model.
module tb_activation_buffer_writer;
   localparam int DW = 7;
   localparam int AW = 15;
   localparam int CW = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [CW-1:0] num_elems_i;
   logic          data_valid_i;
   logic [DW-1:0] data_i;
   logic          data_ready_o;
   logic          buffer_wr_en_o;
   logic [AW-1:0] buffer_wr_addr_o;
   logic [4*DW-1:0] buffer_data_o;
   logic          busy_o;
   logic          done_o;

   activation_buffer_writer #(.DATA_WIDTH(DW), .BUFFER_ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_elems_i(num_elems_i), .data_valid_i(data_valid_i), .data_i(data_i),
      .data_ready_o(data_ready_o), .buffer_wr_en_o(buffer_wr_en_o),
      .buffer_wr_addr_o(buffer_wr_addr_o), .buffer_data_o(buffer_data_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Observed writes and done pulses, sampled mid-cycle.
   logic [AW-1:0]   wa_q[$];
   logic [4*DW-1:0] wd_q[$];
   int              wc_q[$];
   int              done_n = 0;
   int              done_stamp = -1;
   always @(negedge clk) begin
      if (buffer_wr_en_o) begin
         wa_q.push_back(buffer_wr_addr_o);
         wd_q.push_back(buffer_data_o);
         wc_q.push_back(cyc);
      end
      if (done_o) begin
         done_n++;
         done_stamp = cyc;
      end
   end

   logic [DW-1:0]   elems[$];
   logic [AW-1:0]   exp_a[$];
   logic [4*DW-1:0] exp_d[$];
   int              start_stamp;
   int              last_acc;

   typedef struct {
      logic [AW-1:0]   base;
      int              num;
      logic [DW-1:0]   first;
      int              mode;     // 0 continuous, 1 toggling valid, 2 random valid
      bit              mid;      // pulse start_i during the job
      int              nwr;
      logic [AW-1:0]   a0, a1;
      logic [4*DW-1:0] d0, d1;
   } vec_t;

   vec_t tbl[6];

   function automatic logic [4*DW-1:0] pk(input logic [DW-1:0] l3, l2, l1, l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_obs();
      wa_q.delete(); wd_q.delete(); wc_q.delete();
      done_n = 0; done_stamp = -1;
   endtask

   // Word-level model: ceil(n/4) words, lane i of word w holds element 4w+i or zero.
   task automatic build_model(input logic [AW-1:0] b, input int n);
      logic [4*DW-1:0] w;
      exp_a.delete(); exp_d.delete();
      for (int k = 0; k < (n + 3) / 4; k++) begin
         w = '0;
         for (int l = 0; l < 4; l++)
            if (4 * k + l < n) w[l*DW +: DW] = elems[4*k+l];
         exp_a.push_back(AW'(b + AW'(k)));
         exp_d.push_back(w);
      end
   endtask

   task automatic run_job(input string nm, input logic [AW-1:0] b, input int n,
                          input int mode, input bit mid);
      int  idx, guard;
      bit  acc;
      clear_obs();
      start_i = 1'b1; base_addr_i = b; num_elems_i = CW'(n);
      @(posedge clk); #1;
      start_stamp = cyc; start_i = 1'b0;
      idx = 0; guard = 0;
      while (idx < n && guard < 400) begin
         data_valid_i = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
         data_i = elems[idx];
         if (mid && idx == 2) begin
            start_i = 1'b1; base_addr_i = ~b; num_elems_i = CW'(3);
         end
         acc = data_valid_i && data_ready_o;
         @(posedge clk); #1;
         start_i = 1'b0;
         if (acc) begin last_acc = cyc; idx++; end
         guard++;
      end
      data_valid_i = 1'b0;
      chk($sformatf("%s_fed", nm), 64'(idx), 64'(n));
      guard = 0;
      while (done_n == 0 && guard < 30) begin
         @(posedge clk); #2;
         guard++;
      end
      chk($sformatf("%s_done_seen", nm), 64'(done_n != 0), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("%s_done_once", nm), 64'(done_n), 64'(1));
      chk($sformatf("%s_busy_low", nm), 64'(busy_o), 64'(0));
      if (n == 0) chk($sformatf("%s_empty_done_lat", nm), 64'(done_stamp), 64'(start_stamp));
      else if (wc_q.size() > 0) begin
         chk($sformatf("%s_wr_lat", nm), 64'(wc_q[wc_q.size()-1]), 64'(last_acc));
         chk($sformatf("%s_done_with_wr", nm), 64'(done_stamp), 64'(wc_q[wc_q.size()-1]));
      end
   endtask

   task automatic cmp_writes(input string nm);
      chk($sformatf("%s_nwr", nm), 64'(wa_q.size()), 64'(exp_a.size()));
      for (int i = 0; i < wa_q.size() && i < exp_a.size(); i++) begin
         chk($sformatf("%s_addr%0d", nm, i), 64'(wa_q[i]), 64'(exp_a[i]));
         chk($sformatf("%s_data%0d", nm, i), 64'(wd_q[i]), 64'(exp_d[i]));
      end
   endtask

   initial begin
      tbl[0] = '{15'h0010, 8, 7'h01, 0, 1'b0, 2, 15'h0010, 15'h0011, pk(4, 3, 2, 1), pk(8, 7, 6, 5)};
      tbl[1] = '{15'h0020, 5, 7'h11, 0, 1'b0, 2, 15'h0020, 15'h0021,
                 pk(7'h14, 7'h13, 7'h12, 7'h11), pk(0, 0, 0, 7'h15)};
      tbl[2] = '{15'h0030, 4, 7'h21, 1, 1'b0, 1, 15'h0030, 15'h0000,
                 pk(7'h24, 7'h23, 7'h22, 7'h21), '0};
      tbl[3] = '{15'h7FFF, 8, 7'h40, 0, 1'b0, 2, 15'h7FFF, 15'h0000,
                 pk(7'h43, 7'h42, 7'h41, 7'h40), pk(7'h47, 7'h46, 7'h45, 7'h44)};
      tbl[4] = '{15'h0050, 0, 7'h00, 0, 1'b0, 0, 15'h0000, 15'h0000, '0, '0};
      tbl[5] = '{15'h0060, 8, 7'h31, 0, 1'b1, 2, 15'h0060, 15'h0061,
                 pk(7'h34, 7'h33, 7'h32, 7'h31), pk(7'h38, 7'h37, 7'h36, 7'h35)};

      rst = 1'b1; start_i = 1'b0; base_addr_i = '0; num_elems_i = '0;
      data_valid_i = 1'b0; data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", 64'(buffer_wr_en_o), 64'(0));
      chk("rst_ready", 64'(data_ready_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      chk("rst_addr", 64'(buffer_wr_addr_o), 64'(0));
      chk("rst_data", 64'(buffer_data_o), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      for (int t = 0; t < 6; t++) begin
         elems.delete();
         for (int i = 0; i < tbl[t].num; i++) elems.push_back(DW'(tbl[t].first + DW'(i)));
         exp_a.delete(); exp_d.delete();
         if (tbl[t].nwr > 0) begin exp_a.push_back(tbl[t].a0); exp_d.push_back(tbl[t].d0); end
         if (tbl[t].nwr > 1) begin exp_a.push_back(tbl[t].a1); exp_d.push_back(tbl[t].d1); end
         run_job($sformatf("vec%0d", t), tbl[t].base, tbl[t].num, tbl[t].mode, tbl[t].mid);
         cmp_writes($sformatf("vec%0d", t));
      end

      // Reset after two of four elements: nothing written, no done, outputs cleared.
      clear_obs();
      start_i = 1'b1; base_addr_i = 15'h0100; num_elems_i = CW'(4);
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         data_valid_i = 1'b1; data_i = DW'(7'h70 + i);
         @(posedge clk); #1;
      end
      data_valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", 64'(busy_o), 64'(0));
      chk("midrst_ready", 64'(data_ready_o), 64'(0));
      chk("midrst_wr_en", 64'(buffer_wr_en_o), 64'(0));
      chk("midrst_done", 64'(done_o), 64'(0));
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_writes", 64'(wa_q.size()), 64'(0));
      chk("midrst_no_done", 64'(done_n), 64'(0));
      elems.delete();
      for (int i = 0; i < 4; i++) elems.push_back(DW'(7'h05 + i));
      exp_a.delete(); exp_d.delete();
      exp_a.push_back(15'h0200); exp_d.push_back(pk(7'h08, 7'h07, 7'h06, 7'h05));
      run_job("postrst", 15'h0200, 4, 0, 1'b0);
      cmp_writes("postrst");

      for (int r = 0; r < 25; r++) begin
         logic [AW-1:0] b;
         int n;
         b = AW'($urandom);
         if (r % 5 == 0) b = AW'(15'h7FFE);
         n = $urandom_range(0, 13);
         elems.delete();
         for (int i = 0; i < n; i++) elems.push_back(DW'($urandom));
         build_model(b, n);
         run_job($sformatf("rnd%0d", r), b, n, 2, 1'b0);
         cmp_writes($sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
